// File: rtl/em_rr_input_arbiter.sv
// Packet-granular round-robin merge of NUM_PORTS AXI4-Stream sources into one
// registered master stream; a grant is held from first beat through tlast.
module em_rr_input_arbiter #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_PORTS          = 4
) (
    input  logic                                        axi_aclk,
    input  logic                                        axi_reset,
    input  logic                                        sw_rst,
    input  logic                                        arb_enable,
    input  logic [NUM_PORTS-1:0]                        port_mask,
    input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb,
    input  logic [NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
    input  logic [NUM_PORTS-1:0]                        s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]                        s_axis_tlast,
    output logic [NUM_PORTS-1:0]                        s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]                m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]              m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]               m_axis_tuser,
    output logic                                        m_axis_tvalid,
    input  logic                                        m_axis_tready,
    output logic                                        m_axis_tlast,
    output logic [$clog2(NUM_PORTS)-1:0]                cur_grant,
    output logic [31:0]                                 pkt_cnt
);

    localparam int DW = C_AXIS_DATA_WIDTH;
    localparam int SW = C_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_AXIS_TUSER_WIDTH;
    localparam int GW = $clog2(NUM_PORTS);

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [GW-1:0]          grant_next;
    logic [GW-1:0]          cand;
    logic                   found;
    logic                   rst;
    logic                   out_free;
    logic                   load;
    logic [NUM_PORTS-1:0]   eligible;
    logic [DW-1:0]          sel_data;
    logic [SW-1:0]          sel_strb;
    logic [UW-1:0]          sel_user;
    logic                   sel_valid;
    logic                   sel_last;

    assign rst      = axi_reset | sw_rst;
    assign out_free = ~m_axis_tvalid | m_axis_tready;
    assign eligible = s_axis_tvalid & port_mask & {NUM_PORTS{arb_enable}};
    assign load     = (state == PKT) & out_free & sel_valid;

    always_comb begin
        sel_data  = '0;
        sel_strb  = '0;
        sel_user  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (cur_grant == GW'(i)) begin
                sel_data  = s_axis_tdata[i*DW +: DW];
                sel_strb  = s_axis_tstrb[i*SW +: SW];
                sel_user  = s_axis_tuser[i*UW +: UW];
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
            end
        end
    end

    // Only the granted port ever sees ready, and only while the output slot can take a beat.
    always_comb begin
        s_axis_tready = '0;
        if ((state == PKT) && out_free) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                s_axis_tready[i] = (cur_grant == GW'(i));
            end
        end
    end

    // Search starts just after the last grant, so the previous winner is tried last.
    always_comb begin
        state_next = state;
        grant_next = cur_grant;
        found      = 1'b0;
        cand       = '0;
        case (state)
            IDLE: begin
                for (int k = 1; k <= NUM_PORTS; k++) begin
                    cand = GW'((int'(cur_grant) + k) % NUM_PORTS);
                    if (!found && eligible[cand]) begin
                        found      = 1'b1;
                        grant_next = cand;
                    end
                end
                if (found) begin
                    state_next = PKT;
                end
            end
            PKT: begin
                if (load && sel_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            state         <= IDLE;
            cur_grant     <= GW'(NUM_PORTS - 1);
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tstrb  <= '0;
            m_axis_tuser  <= '0;
            pkt_cnt       <= 32'd0;
        end else begin
            state     <= state_next;
            cur_grant <= grant_next;
            if (load) begin
                m_axis_tdata  <= sel_data;
                m_axis_tstrb  <= sel_strb;
                m_axis_tuser  <= sel_user;
                m_axis_tlast  <= sel_last;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                pkt_cnt <= pkt_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_em_rr_input_arbiter.sv
// Directed bench for em_rr_input_arbiter: a cycle table for the basic packet and
// mask cases, then behavioural sources for rotation, enable, stall and sw_rst cases.
module tb_em_rr_input_arbiter;

    localparam int DW = 256;
    localparam int SW = DW / 8;
    localparam int UW = 128;
    localparam int NP = 4;

    logic               clk;
    logic               axi_reset;
    logic               sw_rst;
    logic               arb_enable;
    logic [NP-1:0]      port_mask;
    logic [NP*DW-1:0]   s_tdata;
    logic [NP*SW-1:0]   s_tstrb;
    logic [NP*UW-1:0]   s_tuser;
    logic [NP-1:0]      s_tvalid;
    logic [NP-1:0]      s_tlast;
    logic [NP-1:0]      s_tready;
    logic [DW-1:0]      m_tdata;
    logic [SW-1:0]      m_tstrb;
    logic [UW-1:0]      m_tuser;
    logic               m_tvalid;
    logic               m_tready;
    logic               m_tlast;
    logic [1:0]         cur_grant;
    logic [31:0]        pkt_cnt;

    em_rr_input_arbiter #(
        .C_AXIS_DATA_WIDTH (DW),
        .C_AXIS_TUSER_WIDTH(UW),
        .NUM_PORTS         (NP)
    ) dut (
        .axi_aclk     (clk),
        .axi_reset    (axi_reset),
        .sw_rst       (sw_rst),
        .arb_enable   (arb_enable),
        .port_mask    (port_mask),
        .s_axis_tdata (s_tdata),
        .s_axis_tstrb (s_tstrb),
        .s_axis_tuser (s_tuser),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tlast (s_tlast),
        .s_axis_tready(s_tready),
        .m_axis_tdata (m_tdata),
        .m_axis_tstrb (m_tstrb),
        .m_axis_tuser (m_tuser),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tlast (m_tlast),
        .cur_grant    (cur_grant),
        .pkt_cnt      (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Source model state
    int             src_len [NP];
    int             src_beat[NP];
    int             src_pkt [NP];
    int             src_left[NP];
    logic [NP-1:0]  hs;
    logic [NP-1:0]  rdy_seen;
    logic [15:0]    outq[$];
    int             stall_cycles;
    int             rdy_in_stall;
    int             hold_err;
    logic           prev_stall;
    logic [15:0]    prev_tag;

    typedef struct packed {
        logic [3:0]  tv;
        logic [3:0]  tl;
        logic [3:0]  msk;
        logic [7:0]  beat;
        logic [3:0]  e_rdy;
        logic        e_mv;
        logic        e_ml;
        logic [15:0] e_tag;
        logic [1:0]  e_gr;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [15:0] tag_of(int p, int pk, int b);
        return {4'(p), 4'(pk), 8'(b)};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(string name, int k, logic [15:0] exp);
        logic [15:0] a;
        a = 'x;
        if (k < outq.size()) a = outq[k];
        chk($sformatf("%s[%0d]", name, k), 64'(a), 64'(exp));
    endtask

    task automatic set_port(int i, logic v, logic l, logic [15:0] tag);
        s_tvalid[i]            = v;
        s_tlast[i]             = l;
        s_tdata[i*DW +: DW]    = {{(DW-16){1'b0}}, tag};
        s_tuser[i*UW +: UW]    = {{(UW-16){1'b0}}, tag ^ 16'hA5A5};
        s_tstrb[i*SW +: SW]    = SW'(1) << i;
    endtask

    task automatic do_reset();
        @(negedge clk);
        axi_reset  = 1'b1;
        sw_rst     = 1'b0;
        arb_enable = 1'b1;
        port_mask  = 4'hF;
        m_tready   = 1'b1;
        for (int i = 0; i < NP; i++) begin
            set_port(i, 1'b0, 1'b0, 16'h0);
            src_len[i]  = 1;
            src_beat[i] = 0;
            src_pkt[i]  = 0;
            src_left[i] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        axi_reset    = 1'b0;
        outq.delete();
        stall_cycles = 0;
        rdy_in_stall = 0;
        hold_err     = 0;
        prev_stall   = 1'b0;
        rdy_seen     = '0;
    endtask

    // One clock of the behavioural sources and the output sink.
    task automatic step();
        logic inr;
        @(negedge clk);
        for (int i = 0; i < NP; i++) begin
            set_port(i, src_left[i] != 0,
                     (src_left[i] != 0) && (src_beat[i] == src_len[i] - 1),
                     tag_of(i, src_pkt[i], src_beat[i]));
        end
        #4;
        inr = axi_reset | sw_rst;
        hs  = inr ? '0 : (s_tvalid & s_tready);
        rdy_seen |= s_tready;
        if (!inr) begin
            if (prev_stall && !(m_tvalid && m_tdata[15:0] == prev_tag)) hold_err++;
            prev_stall = m_tvalid && !m_tready;
            prev_tag   = m_tdata[15:0];
            if (m_tvalid && !m_tready) begin
                stall_cycles++;
                if (s_tready != '0) rdy_in_stall++;
            end
            if (m_tvalid && m_tready) outq.push_back(m_tdata[15:0]);
        end else begin
            prev_stall = 1'b0;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (hs[i]) begin
                if (src_beat[i] == src_len[i] - 1) begin
                    src_beat[i] = 0;
                    src_pkt[i]++;
                    src_left[i]--;
                end else begin
                    src_beat[i]++;
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [3:0] mr_pat[12];

    initial begin
        axi_reset = 1'b1;
        sw_rst    = 1'b0;
        s_tvalid  = '0;
        s_tlast   = '0;
        s_tdata   = '0;
        s_tstrb   = '0;
        s_tuser   = '0;
        //            tv    tl    msk   beat   e_rdy e_mv  e_ml  e_tag     gr    cnt
        tbl[0] = '{4'h4, 4'h0, 4'hF, 8'd1, 4'h0, 1'b0, 1'b0, 16'h0000, 2'd2, 32'd0};
        tbl[1] = '{4'h4, 4'h0, 4'hF, 8'd1, 4'h4, 1'b1, 1'b0, 16'h2001, 2'd2, 32'd0};
        tbl[2] = '{4'h4, 4'h0, 4'hF, 8'd2, 4'h4, 1'b1, 1'b0, 16'h2002, 2'd2, 32'd0};
        tbl[3] = '{4'h4, 4'h4, 4'hF, 8'd3, 4'h4, 1'b1, 1'b1, 16'h2003, 2'd2, 32'd0};
        tbl[4] = '{4'h0, 4'h0, 4'hF, 8'd0, 4'h0, 1'b0, 1'b0, 16'h0000, 2'd2, 32'd1};
        tbl[5] = '{4'h9, 4'h9, 4'h7, 8'd4, 4'h0, 1'b0, 1'b0, 16'h0000, 2'd0, 32'd1};
        tbl[6] = '{4'h9, 4'h9, 4'h7, 8'd4, 4'h1, 1'b1, 1'b1, 16'h0004, 2'd0, 32'd1};
        tbl[7] = '{4'h9, 4'h9, 4'h7, 8'd4, 4'h0, 1'b0, 1'b0, 16'h0000, 2'd0, 32'd2};
        tbl[8] = '{4'h9, 4'h9, 4'h7, 8'd4, 4'h1, 1'b1, 1'b1, 16'h0004, 2'd0, 32'd2};
        tbl[9] = '{4'h0, 4'h0, 4'h7, 8'd0, 4'h0, 1'b0, 1'b0, 16'h0000, 2'd0, 32'd3};
        mr_pat = '{4'd1, 4'd1, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};

        do_reset();
        @(posedge clk);
        #1;
        chk("rst_mvalid", 64'(m_tvalid), 64'd0);
        chk("rst_tready", 64'(s_tready), 64'd0);
        chk("rst_grant",  64'(cur_grant), 64'd3);
        chk("rst_cnt",    64'(pkt_cnt), 64'd0);

        // 3-beat packet on port 2, then ports 0 and 3 with port 3 masked
        for (int r = 0; r < 10; r++) begin
            @(negedge clk);
            for (int i = 0; i < NP; i++) begin
                set_port(i, tbl[r].tv[i], tbl[r].tl[i], tag_of(i, 0, int'(tbl[r].beat)));
            end
            port_mask = tbl[r].msk;
            #4;
            chk($sformatf("v%0d_tready", r), 64'(s_tready), 64'(tbl[r].e_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_mvalid", r), 64'(m_tvalid), 64'(tbl[r].e_mv));
            chk($sformatf("v%0d_grant", r), 64'(cur_grant), 64'(tbl[r].e_gr));
            chk($sformatf("v%0d_cnt", r), 64'(pkt_cnt), 64'(tbl[r].e_cnt));
            if (tbl[r].e_mv) begin
                chk($sformatf("v%0d_mlast", r), 64'(m_tlast), 64'(tbl[r].e_ml));
                chk($sformatf("v%0d_mdata", r), 64'(m_tdata[15:0]), 64'(tbl[r].e_tag));
                chk($sformatf("v%0d_mstrb", r), 64'(m_tstrb), 64'(SW'(1) << tbl[r].e_tag[15:12]));
                chk($sformatf("v%0d_muser", r), 64'(m_tuser[15:0]), 64'(tbl[r].e_tag ^ 16'hA5A5));
            end
        end

        // All four ports offering 2-beat packets back to back
        do_reset();
        for (int i = 0; i < NP; i++) begin
            src_len[i]  = 2;
            src_left[i] = 100;
        end
        for (int t = 0; t < 60 && pkt_cnt != 32'd8; t++) step();
        for (int i = 0; i < NP; i++) src_left[i] = 0;
        chk("rot_cnt", 64'(pkt_cnt), 64'd8);
        chk("rot_size", 64'(outq.size()), 64'd16);
        for (int n = 0; n < 8; n++) begin
            for (int b = 0; b < 2; b++) begin
                chk_out("rot_beat", 2 * n + b, tag_of(n % 4, n / 4, b));
            end
        end

        // arb_enable dropped mid-packet on port 1 while port 0 waits
        do_reset();
        src_len[1]  = 4;
        src_left[1] = 1;
        for (int t = 0; t < 20 && src_beat[1] != 2; t++) step();
        arb_enable  = 1'b0;
        src_len[0]  = 4;
        src_left[0] = 1;
        rdy_seen    = '0;
        for (int t = 0; t < 20 && src_pkt[1] != 1; t++) step();
        repeat (6) step();
        chk("en_size", 64'(outq.size()), 64'd4);
        for (int k = 0; k < 4; k++) chk_out("en_p1", k, tag_of(1, 0, k));
        chk("en_rdy0", 64'(rdy_seen[0]), 64'd0);
        chk("en_grant", 64'(cur_grant), 64'd1);
        chk("en_cnt", 64'(pkt_cnt), 64'd1);
        arb_enable = 1'b1;
        outq.delete();
        for (int t = 0; t < 20 && src_left[0] != 0; t++) step();
        repeat (3) step();
        chk("en2_size", 64'(outq.size()), 64'd4);
        for (int k = 0; k < 4; k++) chk_out("en2_p0", k, tag_of(0, 0, k));
        chk("en2_grant", 64'(cur_grant), 64'd0);
        chk("en2_cnt", 64'(pkt_cnt), 64'd2);

        // Downstream stalls during a 4-beat packet
        do_reset();
        src_len[0]  = 4;
        src_left[0] = 1;
        for (int k = 0; k < 12; k++) begin
            m_tready = mr_pat[k][0];
            step();
        end
        chk("stall_size", 64'(outq.size()), 64'd4);
        for (int k = 0; k < 4; k++) chk_out("stall_beat", k, tag_of(0, 0, k));
        chk("stall_cycles", 64'(stall_cycles), 64'd2);
        chk("stall_rdy", 64'(rdy_in_stall), 64'd0);
        chk("stall_hold", 64'(hold_err), 64'd0);
        chk("stall_cnt", 64'(pkt_cnt), 64'd1);

        // sw_rst in the middle of a 5-beat packet on port 0
        m_tready    = 1'b1;
        src_len[0]  = 5;
        src_left[0] = 1;
        outq.delete();
        for (int t = 0; t < 20 && src_beat[0] != 2; t++) step();
        sw_rst = 1'b1;
        step();
        sw_rst = 1'b0;
        chk("swr_mvalid", 64'(m_tvalid), 64'd0);
        chk("swr_cnt", 64'(pkt_cnt), 64'd0);
        chk("swr_grant", 64'(cur_grant), 64'd3);
        chk("swr_tready", 64'(s_tready), 64'd0);
        outq.delete();
        for (int t = 0; t < 20 && src_left[0] != 0; t++) step();
        repeat (3) step();
        chk("swr_size", 64'(outq.size()), 64'd3);
        for (int k = 0; k < 3; k++) chk_out("swr_beat", k, tag_of(0, 1, k + 2));
        chk("swr_cnt2", 64'(pkt_cnt), 64'd1);
        chk("swr_grant2", 64'(cur_grant), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
